// File: rtl/sample_mixer_mc_if.sv
// Shared sample ROM bus: the mixer drives the address and the ROM returns
// the signed sample one clk later.
interface sample_mixer_mc_if #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 8
);
    logic [ADDR_W-1:0] rom_addr;
    logic [DATA_W-1:0] rom_data;

    modport master (output rom_addr, input rom_data);
    modport slave  (input rom_addr, output rom_data);
endinterface

// File: rtl/sample_mixer_mc.sv
// Multi-channel sample playback engine: NUM_CH channels share one ROM through
// a sequenced sweep (START, ADDR/DATA per channel, MIX) and are summed to audio.
module sample_mixer_mc #(
    parameter int NUM_CH = 4,
    parameter int ADDR_W = 16,
    parameter int DATA_W = 8,
    parameter int DIV_W  = 12,
    parameter int OUT_W  = 16
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     pause,
    input  logic [NUM_CH-1:0]        trig,
    input  logic [2*NUM_CH-1:0]      ch_mode,
    input  logic [ADDR_W*NUM_CH-1:0] ch_start,
    input  logic [ADDR_W*NUM_CH-1:0] ch_len,
    input  logic [DIV_W-1:0]         rate_div,
    sample_mixer_mc_if.master        rom,
    output logic [NUM_CH-1:0]        playing,
    output logic [OUT_W-1:0]         audio
);
    localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int SH   = OUT_W - DATA_W - $clog2(NUM_CH);

    typedef enum logic [2:0] {S_IDLE, S_START, S_ADDR, S_DATA, S_MIX} state_e;

    state_e                   state_q, state_d;
    logic [CH_W-1:0]          ch_q, ch_d;
    logic [DIV_W-1:0]         cnt_q, cnt_d;
    logic                     tick_pend_q, tick_pend_d;
    logic [NUM_CH-1:0]        trig_prev_q;
    logic [NUM_CH-1:0]        pend_q, pend_d, pend_set, pend_clr;
    logic [NUM_CH-1:0]        playing_q, playing_d;
    logic [ADDR_W-1:0]        pos_q [NUM_CH];
    logic [ADDR_W-1:0]        pos_d [NUM_CH];
    logic signed [DATA_W-1:0] hold_q [NUM_CH];
    logic signed [DATA_W-1:0] hold_d [NUM_CH];
    logic [ADDR_W-1:0]        rom_addr_q, rom_addr_d;
    logic [OUT_W-1:0]         audio_q, audio_d;

    logic [ADDR_W-1:0]        start_a [NUM_CH];
    logic [ADDR_W-1:0]        len_a   [NUM_CH];
    logic [1:0]               mode_a  [NUM_CH];
    logic [OUT_W-1:0]         sum;
    logic [ADDR_W-1:0]        addr_now;
    logic                     tick;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_IDLE;
            ch_q        <= '0;
            cnt_q       <= '0;
            tick_pend_q <= 1'b0;
            trig_prev_q <= '0;
            pend_q      <= '0;
            playing_q   <= '0;
            rom_addr_q  <= '0;
            audio_q     <= '0;
            for (int unsigned i = 0; i < NUM_CH; i++) begin
                pos_q[i]  <= '0;
                hold_q[i] <= '0;
            end
        end else begin
            state_q     <= state_d;
            ch_q        <= ch_d;
            cnt_q       <= cnt_d;
            tick_pend_q <= tick_pend_d;
            trig_prev_q <= trig;
            pend_q      <= pend_d;
            playing_q   <= playing_d;
            rom_addr_q  <= rom_addr_d;
            audio_q     <= audio_d;
            pos_q       <= pos_d;
            hold_q      <= hold_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        ch_d        = ch_q;
        cnt_d       = cnt_q;
        tick_pend_d = tick_pend_q;
        pend_set    = '0;
        pend_clr    = '0;
        playing_d   = playing_q;
        pos_d       = pos_q;
        hold_d      = hold_q;
        rom_addr_d  = rom_addr_q;
        audio_d     = audio_q;
        tick        = 1'b0;
        sum         = '0;
        for (int unsigned i = 0; i < NUM_CH; i++) begin
            start_a[i] = ch_start[i*ADDR_W +: ADDR_W];
            len_a[i]   = ch_len[i*ADDR_W +: ADDR_W];
            mode_a[i]  = ch_mode[2*i +: 2];
            sum = sum + {{(OUT_W-DATA_W){hold_q[i][DATA_W-1]}}, hold_q[i]};
        end
        addr_now = start_a[ch_q] + pos_q[ch_q];

        if (!pause) begin
            tick        = (cnt_q == '0);
            cnt_d       = tick ? rate_div : cnt_q - 1'b1;
            tick_pend_d = tick_pend_q | tick;

            // Restart mode accepts edges while playing; the others only when idle.
            for (int unsigned i = 0; i < NUM_CH; i++) begin
                if (trig[i] && !trig_prev_q[i] && len_a[i] != '0 &&
                    (mode_a[i] == 2'd1 || !playing_q[i]))
                    pend_set[i] = 1'b1;
            end

            case (state_q)
                S_IDLE: begin
                    if (tick || tick_pend_q) begin
                        state_d     = S_START;
                        tick_pend_d = 1'b0;
                    end
                end
                S_START: begin
                    for (int unsigned i = 0; i < NUM_CH; i++) begin
                        if (pend_q[i]) begin
                            pos_d[i]     = '0;
                            playing_d[i] = 1'b1;
                            pend_clr[i]  = 1'b1;
                        end else if (playing_q[i] && pos_q[i] == len_a[i]) begin
                            if (mode_a[i] == 2'd2 && trig[i]) begin
                                pos_d[i] = '0;
                            end else begin
                                playing_d[i] = 1'b0;
                                hold_d[i]    = '0;
                            end
                        end
                    end
                    ch_d    = '0;
                    state_d = S_ADDR;
                end
                S_ADDR: begin
                    if (playing_q[ch_q])
                        rom_addr_d = addr_now;
                    state_d = S_DATA;
                end
                S_DATA: begin
                    if (playing_q[ch_q]) begin
                        hold_d[ch_q] = rom.rom_data;
                        pos_d[ch_q]  = pos_q[ch_q] + 1'b1;
                    end
                    if (ch_q == CH_W'(NUM_CH - 1)) begin
                        state_d = S_MIX;
                    end else begin
                        ch_d    = ch_q + 1'b1;
                        state_d = S_ADDR;
                    end
                end
                S_MIX: begin
                    audio_d = sum << SH;
                    state_d = S_IDLE;
                end
                default: state_d = S_IDLE;
            endcase
        end
        pend_d = (pend_q & ~pend_clr) | pend_set;
    end

    // Address is presented during ADDR so a registered ROM has data in DATA.
    assign rom.rom_addr = (state_q == S_ADDR && playing_q[ch_q]) ? addr_now : rom_addr_q;
    assign playing      = playing_q;
    assign audio        = audio_q;

endmodule

// File: tb/tb_sample_mixer_mc.sv
// Directed bench for sample_mixer_mc: a 1-channel and a 4-channel instance
// share one registered ROM image; checks are taken once per 16-clk sweep.
module tb_sample_mixer_mc;
    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset, pause;
    logic [11:0] rate_div;
    logic        trig1, playing1;
    logic [1:0]  mode1;
    logic [15:0] start1, len1, audio1;
    logic [3:0]  trig4, playing4;
    logic [7:0]  mode4;
    logic [63:0] start4, len4;
    logic [15:0] audio4;

    logic [7:0]  mem [0:65535];

    sample_mixer_mc_if #(.ADDR_W(16), .DATA_W(8)) rom1 ();
    sample_mixer_mc_if #(.ADDR_W(16), .DATA_W(8)) rom4 ();

    always @(posedge clk) begin
        rom1.rom_data <= mem[rom1.rom_addr];
        rom4.rom_data <= mem[rom4.rom_addr];
    end

    sample_mixer_mc #(.NUM_CH(1), .ADDR_W(16), .DATA_W(8), .DIV_W(12), .OUT_W(16)) u1 (
        .clk(clk), .reset(reset), .pause(pause), .trig(trig1), .ch_mode(mode1),
        .ch_start(start1), .ch_len(len1), .rate_div(rate_div), .rom(rom1),
        .playing(playing1), .audio(audio1));

    sample_mixer_mc #(.NUM_CH(4), .ADDR_W(16), .DATA_W(8), .DIV_W(12), .OUT_W(16)) u4 (
        .clk(clk), .reset(reset), .pause(pause), .trig(trig4), .ch_mode(mode4),
        .ch_start(start4), .ch_len(len4), .rate_div(rate_div), .rom(rom4),
        .playing(playing4), .audio(audio4));

    int errors = 0;
    int checks = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Ends at the phase point: 1 time unit after the edge that applies START.
    task automatic do_reset();
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
    endtask

    // One full sweep period; optional trigger pulses lasting one clk.
    task automatic sweep(input logic p1, input logic [3:0] p4);
        trig1 = trig1 | p1;
        trig4 = trig4 | p4;
        @(posedge clk);
        #1;
        trig1 = trig1 & ~p1;
        trig4 = trig4 & ~p4;
        repeat (15) @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic        p1;
        logic [3:0]  p4;
        logic [15:0] a1;
        logic        pl1;
        logic [15:0] a4;
        logic [3:0]  pl4;
    } vec_t;

    vec_t tv [10];

    function automatic logic [15:0] sc6(input logic [7:0] v);
        return {{8{v[7]}}, v} << 6;
    endfunction

    initial begin
        for (int a = 0; a < 65536; a++) mem[a] = 8'h00;
        mem[16'h0100] = 8'h10; mem[16'h0101] = 8'h20; mem[16'h0102] = 8'hF0;
        mem[16'h0200] = 8'h7F; mem[16'h0201] = 8'h01; mem[16'h0202] = 8'h02;
        mem[16'h0300] = 8'h7F; mem[16'h0301] = 8'h7F;
        mem[16'h0400] = 8'h11; mem[16'h0401] = 8'h22; mem[16'h0402] = 8'h33; mem[16'h0403] = 8'h44;
        for (int j = 0; j < 100; j++) mem[16'h1000 + j] = 8'(j + 1);
        for (int j = 0; j < 8; j++)   mem[16'h0500 + j] = 8'(8'h21 + j);
        mem[16'h0600] = 8'h55;

        tv[0] = '{1'b1, 4'b0000, 16'h0000, 1'b1, 16'h0000, 4'b0000};
        tv[1] = '{1'b0, 4'b0000, 16'h1000, 1'b1, 16'h0000, 4'b0000};
        tv[2] = '{1'b0, 4'b0000, 16'h2000, 1'b1, 16'h0000, 4'b0000};
        tv[3] = '{1'b0, 4'b0000, 16'hF000, 1'b0, 16'h0000, 4'b0000};
        tv[4] = '{1'b0, 4'b0000, 16'h0000, 1'b0, 16'h0000, 4'b0000};
        tv[5] = '{1'b0, 4'b0011, 16'h0000, 1'b0, 16'h0000, 4'b0011};
        tv[6] = '{1'b0, 4'b0000, 16'h0000, 1'b0, 16'h3F80, 4'b0011};
        tv[7] = '{1'b0, 4'b0001, 16'h0000, 1'b0, 16'h2000, 4'b0001};
        tv[8] = '{1'b0, 4'b0000, 16'h0000, 1'b0, 16'h0080, 4'b0000};
        tv[9] = '{1'b0, 4'b0000, 16'h0000, 1'b0, 16'h0000, 4'b0000};

        pause = 1'b0; trig1 = 1'b0; trig4 = '0; rate_div = 12'd15;
        mode1 = 2'd0; start1 = 16'h0100; len1 = 16'd3;
        mode4 = '0;
        start4 = {16'h0600, 16'h1000, 16'h0300, 16'h0200};
        len4   = {16'd0,    16'd100,  16'd2,    16'd3};
        reset = 1'b1;
        @(posedge clk);
        #1;
        check("reset_audio1", audio1, 16'h0000);
        check("reset_audio4", audio4, 16'h0000);
        check("reset_playing4", playing4, 4'b0000);
        check("reset_rom_addr4", rom4.rom_addr, 16'h0000);
        do_reset();

        // One-shot playback (single channel) and 4-channel mix with ignored retrigger
        for (int i = 0; i < 10; i++) begin
            sweep(tv[i].p1, tv[i].p4);
            check($sformatf("vec%0d_audio1", i), audio1, tv[i].a1);
            check($sformatf("vec%0d_playing1", i), playing1, tv[i].pl1);
            check($sformatf("vec%0d_audio4", i), audio4, tv[i].a4);
            check($sformatf("vec%0d_playing4", i), playing4, tv[i].pl4);
        end

        // Restart mode on ch2, retrigger at pos 50
        mode4[5:4] = 2'd1;
        sweep(1'b0, 4'b0100);
        check("m1_start_playing", playing4, 4'b0100);
        for (int n = 0; n < 50; n++) begin
            sweep(1'b0, 4'b0000);
            check($sformatf("m1_audio_%0d", n), audio4, sc6(8'(n + 1)));
            check($sformatf("m1_addr_%0d", n), rom4.rom_addr, 16'h1000 + 16'(n));
            check($sformatf("m1_playing_%0d", n), playing4, 4'b0100);
        end
        sweep(1'b0, 4'b0100);
        check("m1_pos50_audio", audio4, sc6(8'd51));
        check("m1_pos50_addr", rom4.rom_addr, 16'h1032);
        check("m1_retrig_playing", playing4, 4'b0100);
        sweep(1'b0, 4'b0000);
        check("m1_restart_audio", audio4, sc6(8'd1));
        check("m1_restart_addr", rom4.rom_addr, 16'h1000);
        check("m1_restart_playing", playing4, 4'b0100);

        // Reset in the middle of a sweep
        repeat (3) @(posedge clk);
        #1 reset = 1'b1;
        @(posedge clk);
        #1;
        check("midrst_playing", playing4, 4'b0000);
        check("midrst_audio", audio4, 16'h0000);
        check("midrst_rom_addr", rom4.rom_addr, 16'h0000);
        do_reset();
        sweep(1'b0, 4'b1100);
        check("postrst_playing", playing4, 4'b0100);
        sweep(1'b0, 4'b0000);
        check("postrst_audio", audio4, sc6(8'd1));
        check("postrst_addr", rom4.rom_addr, 16'h1000);
        check("len0_not_playing", playing4, 4'b0100);

        // Loop-while-held mode on ch1
        do_reset();
        mode4 = 8'b00_00_10_00;
        start4[31:16] = 16'h0400;
        len4[31:16]   = 16'd4;
        trig4[1] = 1'b1;
        for (int m = 1; m <= 14; m++) begin
            sweep(1'b0, 4'b0000);
            if (m == 1) begin
                check("m2_first_playing", playing4, 4'b0010);
            end else if (m <= 13) begin
                check($sformatf("m2_audio_%0d", m), audio4, sc6(mem[16'h0400 + 16'((m - 2) % 4)]));
                check($sformatf("m2_addr_%0d", m), rom4.rom_addr, 16'h0400 + 16'((m - 2) % 4));
                check($sformatf("m2_playing_%0d", m), playing4, (m <= 12) ? 4'b0010 : 4'b0000);
            end else begin
                check("m2_stopped_audio", audio4, 16'h0000);
            end
            if (m == 11) trig4[1] = 1'b0;
        end

        // Pause mid-sweep, with a dropped trigger edge on ch3
        do_reset();
        mode4 = '0;
        start4[15:0]  = 16'h0500; len4[15:0]  = 16'd8;
        start4[63:48] = 16'h0600; len4[63:48] = 16'd5;
        sweep(1'b0, 4'b0001);
        sweep(1'b0, 4'b0000);
        check("pause_pre_audio", audio4, 16'h0840);
        @(posedge clk);
        #1 pause = 1'b1;
        for (int k = 0; k < 50; k++) begin
            @(posedge clk);
            #1;
            if (k == 10) trig4[3] = 1'b1;
            if (k == 20) trig4[3] = 1'b0;
        end
        check("pause_audio", audio4, 16'h0840);
        check("pause_rom_addr", rom4.rom_addr, 16'h0501);
        check("pause_playing", playing4, 4'b0001);
        pause = 1'b0;
        repeat (15) @(posedge clk);
        #1;
        check("resume_audio", audio4, 16'h0880);
        check("resume_playing", playing4, 4'b0001);
        sweep(1'b0, 4'b0000);
        check("resume_audio2", audio4, 16'h08C0);
        check("pause_edge_dropped", playing4, 4'b0001);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
